alu_pipe: RTL

//   Parametrised, pipelined successor of the UART-fed ALU. Operand A, operand B and a 6-bit
//   op code enter through a valid/ready handshake. The registered result leaves through a

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_exec_unit.sv | 71 +++++++
 rtl/alu_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices and default widths for the pipelined ALU
// Purpose: constants shared by alu_exec_unit, alu_pipe and anything driving them.
// Ports: none (package).
// Optional feature macro: ALU_FLAGS_EN (flag bit indices are used only when it is defined).
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 6;
  localparam int FLAGS_W    = 4;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLL = 6'b000000;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - purely combinational ALU execute stage
// Purpose: computes result, unsupported-op indication and (optionally) {N,Z,C,V} flags.
// Ports:
//   i_a, i_b   operands (i_b[SHAMT_W-1:0] is the shift amount for shifts)
//   i_op       operation select
//   o_result   operation result, 0 for unsupported op codes
//   o_op_err   1 when i_op is not a supported op code
//   o_flags    {N,Z,C,V}, only when ALU_FLAGS_EN is defined
// Optional feature macro: ALU_FLAGS_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic [OP_W-1:0]    i_op,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_op_err
`ifdef ALU_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0] o_flags
`endif
);

  logic [SHAMT_W-1:0] w_shamt;
  assign w_shamt = i_b[SHAMT_W-1:0];

  always_comb begin
    o_result = '0;
    o_op_err = 1'b0;
    case (i_op)
      OP_W'(OP_ADD): o_result = i_a + i_b;
      OP_W'(OP_SUB): o_result = i_a - i_b;
      OP_W'(OP_AND): o_result = i_a & i_b;
      OP_W'(OP_OR):  o_result = i_a | i_b;
      OP_W'(OP_XOR): o_result = i_a ^ i_b;
      OP_W'(OP_NOR): o_result = ~(i_a | i_b);
      OP_W'(OP_SRA): o_result = $unsigned($signed(i_a) >>> w_shamt);
      OP_W'(OP_SRL): o_result = i_a >> w_shamt;
      OP_W'(OP_SLL): o_result = i_a << w_shamt;
      default:       o_op_err = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Widened by one bit so the MSB is the carry out / borrow.
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_flags        = '0;
    o_flags[FLG_N] = o_result[DATA_W-1];
    o_flags[FLG_Z] = (o_result == '0);
    if (i_op == OP_W'(OP_ADD)) begin
      o_flags[FLG_C] = w_sum[DATA_W];
      o_flags[FLG_V] = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                       (o_result[DATA_W-1] != i_a[DATA_W-1]);
    end else if (i_op == OP_W'(OP_SUB)) begin
      o_flags[FLG_C] = w_diff[DATA_W];
      o_flags[FLG_V] = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                       (o_result[DATA_W-1] != i_a[DATA_W-1]);
    end
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipelined ALU between UART RX and TX
// Purpose: S1 captures operands, S2 captures the executed result; 1 op/cycle unstalled.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_dato_a, i_dato_b, i_op_code  operation in; i_valid / o_ready handshake
//   o_resultado, o_op_err          result out; o_valid / i_ready handshake
//   o_flags                        {N,Z,C,V}, only when ALU_FLAGS_EN is defined
// Optional feature macro: ALU_FLAGS_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DATA_W-1:0]  i_dato_a,
  input  logic [DATA_W-1:0]  i_dato_b,
  input  logic [OP_W-1:0]    i_op_code,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [DATA_W-1:0]  o_resultado,
  output logic               o_op_err,
  output logic               o_valid,
  input  logic               i_ready
`ifdef ALU_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0] o_flags
`endif
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [OP_W-1:0]   r_s1_op;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic              r_s2_op_err;

  logic [DATA_W-1:0] w_ex_result;
  logic              w_ex_op_err;
  logic              w_s2_load;
  logic              w_in_xfer;

`ifdef ALU_FLAGS_EN
  logic [FLAGS_W-1:0] w_ex_flags;
  logic [FLAGS_W-1:0] r_s2_flags;
`endif

  // S2 can take a new value when it is empty or its beat leaves this cycle;
  // S1 drains into S2 under the same condition, so it can accept in that cycle too.
  assign w_s2_load = !r_s2_valid || i_ready;
  assign o_ready   = !r_s1_valid || w_s2_load;
  assign w_in_xfer = i_valid && o_ready;

  alu_exec_unit #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .SHAMT_W (SHAMT_W)
  ) u_exec (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_ex_result),
    .o_op_err (w_ex_op_err)
`ifdef ALU_FLAGS_EN
    ,
    .o_flags  (w_ex_flags)
`endif
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= i_dato_a;
      r_s1_b     <= i_dato_b;
      r_s1_op    <= i_op_code;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_op_err <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_s2_flags  <= '0;
`endif
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      // Data is held when S1 is empty so the last result stays on the bus.
      if (r_s1_valid) begin
        r_s2_result <= w_ex_result;
        r_s2_op_err <= w_ex_op_err;
`ifdef ALU_FLAGS_EN
        r_s2_flags  <= w_ex_flags;
`endif
      end
    end
  end

  assign o_valid     = r_s2_valid;
  assign o_resultado = r_s2_result;
  assign o_op_err    = r_s2_op_err;
`ifdef ALU_FLAGS_EN
  assign o_flags     = r_s2_flags;
`endif

endmodule
